// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the future receiver.
// Optional parity support is compiled in with the UART_TX_PARITY_EN macro.
package uart_pkg;

  // Level of the serial line when no frame is in flight (also the stop bit)
  localparam logic IDLE_LEVEL = 1'b1;

  // Default bit period in clock cycles (100 MHz / 115200 baud)
  localparam int CLKS_PER_BAUD_DEFAULT = 868;

  // Transmitter frame sequencer states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

endpackage

// File: rtl/baud_tick.sv
// Restartable bit-period counter. It counts 0..N-1 and wraps; o_tick is high
// on the wrap cycle. i_clr restarts the period from 0 and suppresses the tick
// so a new frame always gets a full first bit period.
module baud_tick #(
  parameter int N = 868
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] r_cnt;

  // Period counter: restart on clear, wrap at the last count
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST) && !i_clr;

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a show-ahead FIFO: pops one word whenever the
// line is idle and the FIFO is non-empty, then sends start, W data bits
// LSB first, optional even parity bit and a stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit after the data bits.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int W             = 8,
  parameter int CLKS_PER_BAUD = CLKS_PER_BAUD_DEFAULT
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_empty,
  input  logic [W-1:0] i_data,
  output logic         o_rd,
  output logic         o_tx,
  output logic         o_busy,
  output logic         o_done
);

  localparam int BW = $clog2(W);
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

  tx_state_t    r_state;
  logic [W-1:0] r_shift;
  logic [BW-1:0] r_bit;
  logic         r_tx;
  logic         r_busy;
  logic         w_pop;
  logic         w_tick;
`ifdef UART_TX_PARITY_EN
  logic         r_par;
`endif

  // Pop is only possible from IDLE, so the FIFO is never read mid-frame
  assign w_pop = (r_state == IDLE) && !i_empty;

  baud_tick #(
    .N(CLKS_PER_BAUD)
  ) u_baud (
    .clk   (clk),
    .i_rst (i_rst),
    .i_clr (w_pop),
    .o_tick(w_tick)
  );

  // Frame sequencer; o_tx is loaded one edge ahead so it changes with the state
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_tx    <= IDLE_LEVEL;
      r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= IDLE_LEVEL;
          if (w_pop) begin
            r_shift <= i_data;
            r_bit   <= '0;
            r_tx    <= ~IDLE_LEVEL;
            r_busy  <= 1'b1;
            r_state <= START;
`ifdef UART_TX_PARITY_EN
            r_par   <= ^i_data;
`endif
          end
        end
        START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 1'b1;
            if (r_bit == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_par;
              r_state <= PARITY;
`else
              r_tx    <= IDLE_LEVEL;
              r_state <= STOP;
`endif
            end else begin
              r_tx <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_tx    <= IDLE_LEVEL;
            r_state <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_tx    <= IDLE_LEVEL;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_rd   = w_pop;
  assign o_tx   = r_tx;
  assign o_busy = r_busy;
  assign o_done = (r_state == STOP) && w_tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx (W=8, CLKS_PER_BAUD=4).
// The line is logged cycle by cycle and each frame is decoded against the
// bytes the FIFO model handed out, using only the frame timing rules.
module tb_fifo_uart_tx;

  localparam int W   = 8;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = W + 3;
`else
  localparam int NBITS = W + 2;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_empty;
  logic [7:0] i_data;
  logic       o_rd;
  logic       o_tx;
  logic       o_busy;
  logic       o_done;

  fifo_uart_tx #(
    .W            (W),
    .CLKS_PER_BAUD(CPB)
  ) dut (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_empty(i_empty),
    .i_data (i_data),
    .o_rd   (o_rd),
    .o_tx   (o_tx),
    .o_busy (o_busy),
    .o_done (o_done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] sent_q[$];
  int         pop_idx[$];
  logic       tx_log[$];
  logic       rd_log[$];
  logic       busy_log[$];
  logic       done_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample mid-cycle, log, model the FIFO pop
  task automatic step(input logic emp, input logic [7:0] dat);
    i_empty = emp;
    i_data  = dat;
    #2;
    tx_log.push_back(o_tx);
    rd_log.push_back(o_rd);
    busy_log.push_back(o_busy);
    done_log.push_back(o_done);
    chk("rd_discipline", {30'd0, o_rd & emp, o_rd & o_busy}, 32'd0);
    if (o_rd === 1'b1 && !emp) begin
      sent_q.push_back(fifo_q.pop_front());
      pop_idx.push_back(cyc);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input bit hold);
    logic       e;
    logic [7:0] d;
    e = (fifo_q.size() == 0) || hold;
    d = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
    step(e, d);
  endtask

  function automatic int count_ones(input int sel, input int a, input int b);
    int n = 0;
    for (int j = a; j < b; j++) begin
      case (sel)
        0: n += int'(rd_log[j]);
        1: n += int'(tx_log[j]);
        2: n += int'(busy_log[j]);
        default: n += int'(done_log[j]);
      endcase
    end
    return n;
  endfunction

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= W) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == W + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  // Decode every frame popped from index 'first' onward
  task automatic check_frames(input int first, input string tag);
    for (int i = first; i < pop_idx.size(); i++) begin
      int         p;
      logic [7:0] b;
      logic [3:0] obs;
      p = pop_idx[i];
      b = sent_q[i];
      chk($sformatf("%s_f%0d_loglen", tag, i), 32'(tx_log.size() > p + FRAME + 1), 32'd1);
      if (tx_log.size() <= p + FRAME + 1) continue;
      for (int k = 0; k < NBITS; k++) begin
        int base;
        base = p + 1 + k * CPB;
        obs = {tx_log[base+3], tx_log[base+2], tx_log[base+1], tx_log[base]};
        chk($sformatf("%s_f%0d_b%02h_bit%0d", tag, i, b, k), 32'(obs), {28'd0, {4{exp_bit(b, k)}}});
      end
      chk($sformatf("%s_f%0d_busy_len", tag, i), 32'(count_ones(2, p + 1, p + FRAME + 1)), 32'(FRAME));
      chk($sformatf("%s_f%0d_busy_edges", tag, i), {30'd0, busy_log[p], busy_log[p+FRAME+1]}, 32'd0);
      chk($sformatf("%s_f%0d_done", tag, i),
          {31'(count_ones(3, p + 1, p + FRAME)), done_log[p+FRAME]}, 32'd1);
      if (i > first)
        chk($sformatf("%s_f%0d_gap_ok", tag, i), 32'(pop_idx[i] - pop_idx[i-1] >= FRAME + 1), 32'd1);
    end
  endtask

  initial begin
    int s;
    int fp;
    int budget;

    // Reset state
    i_rst   = 1'b1;
    i_empty = 1'b1;
    i_data  = 8'h00;
    #1;
    chk("reset_tx", 32'(o_tx), 32'd1);
    chk("reset_rd", 32'(o_rd), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_done", 32'(o_done), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    repeat (3) step(1'b1, 8'h00);

    // Single byte 0xA5
    s  = cyc;
    fp = pop_idx.size();
    fifo_q.push_back(8'hA5);
    repeat (FRAME + 6) feed(1'b0);
    chk("single_rd_cycles", 32'(count_ones(0, s, cyc)), 32'd1);
    chk("single_busy_total", 32'(count_ones(2, s, cyc)), 32'(FRAME));
    chk("single_done_total", 32'(count_ones(3, s, cyc)), 32'd1);
    check_frames(fp, "single");

    // Back-to-back 0x00 then 0xFF
    fp = pop_idx.size();
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    repeat (2 * FRAME + 8) feed(1'b0);
    chk("b2b_pops", 32'(pop_idx.size() - fp), 32'd2);
    if (pop_idx.size() - fp == 2)
      chk("b2b_gap", 32'(pop_idx[fp+1] - pop_idx[fp]), 32'(FRAME + 1));
    check_frames(fp, "b2b");

    // Empty FIFO for 100 cycles
    s = cyc;
    repeat (100) step(1'b1, 8'($urandom));
    chk("empty_rd", 32'(count_ones(0, s, cyc)), 32'd0);
    chk("empty_tx_high", 32'(count_ones(1, s, cyc)), 32'd100);
    chk("empty_busy", 32'(count_ones(2, s, cyc)), 32'd0);

    // Reset in cycle 15 of a 0x3C frame
    fp = pop_idx.size();
    fifo_q.push_back(8'h3C);
    feed(1'b0);
    chk("midrst_popped", 32'(pop_idx.size() - fp), 32'd1);
    repeat (14) step(1'b1, 8'($urandom));
    chk("midrst_busy_before", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    #1;
    chk("midrst_tx_async", 32'(o_tx), 32'd1);
    chk("midrst_busy_async", 32'(o_busy), 32'd0);
    chk("midrst_done_async", 32'(o_done), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    s  = cyc;
    fp = pop_idx.size();
    repeat (60) step(1'b1, 8'($urandom));
    chk("midrst_no_pop", 32'(count_ones(0, s, cyc)), 32'd0);
    chk("midrst_tx_idle", 32'(count_ones(1, s, cyc)), 32'd60);
    chk("midrst_busy_idle", 32'(count_ones(2, s, cyc)), 32'd0);
    fifo_q.push_back(8'h5A);
    repeat (FRAME + 6) feed(1'b0);
    chk("midrst_recover_pops", 32'(pop_idx.size() - fp), 32'd1);
    check_frames(fp, "recover");

    // Randomly gated FIFO over 50 frames
    fp = pop_idx.size();
    for (int n = 0; n < 50; n++) fifo_q.push_back(8'($urandom_range(0, 255)));
    budget = 0;
    while (fifo_q.size() > 0 && budget < 50 * (FRAME + 1) * 4) begin
      feed($urandom_range(0, 3) == 0);
      budget++;
    end
    chk("rand_drained", 32'(fifo_q.size()), 32'd0);
    repeat (FRAME + 6) feed(1'b0);
    chk("rand_pops", 32'(pop_idx.size() - fp), 32'd50);
    check_frames(fp, "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
